// File: rtl/rc4_phase_scheduler.sv
// Sequencer for the RC4 core: runs init -> KSA -> PRGA and owns the single-port S RAM mux.
// Optional per-phase watchdog compiled in with RC4_SCHED_WATCHDOG_EN.
module rc4_phase_scheduler #(
  parameter int WDOG_CYCLES = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [23:0] key_in,
  output logic [23:0] key_out,
  output logic        phase_rst,
  output logic        init_start,
  output logic        ksa_start,
  output logic        prga_start,
  input  logic        init_done,
  input  logic        ksa_done,
  input  logic        prga_done,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  init_data,
  input  logic [7:0]  ksa_data,
  input  logic [7:0]  prga_data,
  input  logic        init_wren,
  input  logic        ksa_wren,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_data,
  output logic        s_wren,
  output logic [1:0]  phase,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_START,
    S_INIT_RUN,
    S_KSA_START,
    S_KSA_RUN,
    S_PRGA_START,
    S_PRGA_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state;
  state_t state_next;
  logic   key_load;
  logic   wdog_trip;

  function automatic logic [1:0] owner_of(input state_t s);
    case (s)
      S_INIT_START, S_INIT_RUN: owner_of = 2'd1;
      S_KSA_START,  S_KSA_RUN:  owner_of = 2'd2;
      S_PRGA_START, S_PRGA_RUN: owner_of = 2'd3;
      default:                  owner_of = 2'd0;
    endcase
  endfunction

  function automatic logic is_busy(input state_t s);
    is_busy = (s == S_INIT_START) || (s == S_INIT_RUN) ||
              (s == S_KSA_START)  || (s == S_KSA_RUN)  ||
              (s == S_PRGA_START) || (s == S_PRGA_RUN);
  endfunction

`ifdef RC4_SCHED_WATCHDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

  logic [15:0] wdog_cnt;
  logic        err_q;

  // Counter reads 0 in the first RUN cycle; trip when this cycle would make it WDOG_CYCLES.
  assign wdog_trip = (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      if ((state == state_next) &&
          ((state == S_INIT_RUN) || (state == S_KSA_RUN) || (state == S_PRGA_RUN)))
        wdog_cnt <= wdog_cnt + 16'd1;
      else
        wdog_cnt <= 16'd0;
      err_q <= (state_next == S_ERROR);
    end
  end

  assign error = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_trip   = 1'b0;
  assign error       = 1'b0;
`endif

  assign key_load = ((state == S_IDLE) || (state == S_DONE)) && go;

  // Done inputs are only looked at in the owning RUN state, so stale levels are harmless.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (go) state_next = S_INIT_START;
      S_INIT_START:   state_next = S_INIT_RUN;
      S_INIT_RUN: begin
        if (init_done)      state_next = S_KSA_START;
        else if (wdog_trip) state_next = S_ERROR;
      end
      S_KSA_START:    state_next = S_KSA_RUN;
      S_KSA_RUN: begin
        if (ksa_done)       state_next = S_PRGA_START;
        else if (wdog_trip) state_next = S_ERROR;
      end
      S_PRGA_START:   state_next = S_PRGA_RUN;
      S_PRGA_RUN: begin
        if (prga_done)      state_next = S_DONE;
        else if (wdog_trip) state_next = S_ERROR;
      end
      S_ERROR:        state_next = S_ERROR;
      default:        state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      key_out    <= 24'd0;
      phase_rst  <= 1'b0;
      init_start <= 1'b0;
      ksa_start  <= 1'b0;
      prga_start <= 1'b0;
      phase      <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      if (key_load) key_out <= key_in;
      phase_rst  <= (state_next == S_INIT_START);
      init_start <= (state_next == S_INIT_START);
      ksa_start  <= (state_next == S_KSA_START);
      prga_start <= (state_next == S_PRGA_START);
      phase      <= owner_of(state_next);
      busy       <= is_busy(state_next);
      done       <= (state_next == S_DONE);
    end
  end

  // S RAM port mux: only the owner's request reaches the RAM; no owner means a quiet port.
  always_comb begin
    s_addr = 8'd0;
    s_data = 8'd0;
    s_wren = 1'b0;
    case (phase)
      2'd1: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      2'd2: begin
        s_addr = ksa_addr;
        s_data = ksa_data;
        s_wren = ksa_wren;
      end
      2'd3: begin
        s_addr = prga_addr;
        s_data = prga_data;
        s_wren = prga_wren;
      end
      default: begin
        s_addr = 8'd0;
        s_data = 8'd0;
        s_wren = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_scheduler.sv
// Directed bench for rc4_phase_scheduler: phase ordering, arbitration, stale done, go filtering, reset.
module tb_rc4_phase_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [23:0] key_in = 24'd0;
  logic [23:0] key_out;
  logic        phase_rst, init_start, ksa_start, prga_start;
  logic        init_done = 1'b0, ksa_done = 1'b0, prga_done = 1'b0;
  logic [7:0]  init_addr = 8'd0, ksa_addr = 8'd0, prga_addr = 8'd0;
  logic [7:0]  init_data = 8'd0, ksa_data = 8'd0, prga_data = 8'd0;
  logic        init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;
  logic [7:0]  s_addr, s_data;
  logic        s_wren;
  logic [1:0]  phase;
  logic        busy, done, error;

  int checks = 0;
  int errors = 0;

  rc4_phase_scheduler #(.WDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .go(go), .key_in(key_in), .key_out(key_out),
    .phase_rst(phase_rst), .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
    .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren),
    .phase(phase), .busy(busy), .done(done), .error(error)
  );

  // Clock and reset: inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    go = 1'b0;
    init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
    init_addr = 8'd0; ksa_addr = 8'd0; prga_addr = 8'd0;
    init_data = 8'd0; ksa_data = 8'd0; prga_data = 8'd0;
    init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Starts a pass from IDLE/DONE and returns in the first KSA_RUN cycle.
  task automatic drive_to_ksa_run(input logic [23:0] key);
    key_in = key; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b1; key_in = 24'hABCDEF;
    init_addr = 8'h11; init_data = 8'h21; init_wren = 1'b1;
    tick();
    tick();
    checks++; if (key_out !== 24'd0) begin errors++; $display("FAIL reset_key_out got %h exp 000000", key_out); end
    checks++; if (init_start !== 1'b0 || phase_rst !== 1'b0) begin errors++; $display("FAIL reset_go_wins init_start %b phase_rst %b exp 0 0", init_start, phase_rst); end
    checks++; if (phase !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_status phase %0d busy %b done %b error %b exp 0 0 0 0", phase, busy, done, error); end
    checks++; if (s_addr !== 8'd0 || s_data !== 8'd0 || s_wren !== 1'b0) begin errors++; $display("FAIL reset_ram_port addr %h data %h wren %b exp 00 00 0", s_addr, s_data, s_wren); end
    reset = 1'b0; go = 1'b0;
    tick();
    checks++; if (init_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle_hold init_start %b busy %b exp 0 0", init_start, busy); end
    clear_inputs();
  endtask

  task automatic test_main_pass();
    do_reset();
    key_in = 24'h000249; go = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (init_start !== 1'b1 || phase_rst !== 1'b1) begin errors++; $display("FAIL pass_init_start init_start %b phase_rst %b exp 1 1", init_start, phase_rst); end
    checks++; if (key_out !== 24'h000249) begin errors++; $display("FAIL pass_key_latch got %h exp 000249", key_out); end
    checks++; if (phase !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL pass_init_owner phase %0d busy %b exp 1 1", phase, busy); end
    tick();
    checks++; if (init_start !== 1'b0 || phase_rst !== 1'b0 || phase !== 2'd1) begin errors++; $display("FAIL pass_init_pulse_width init_start %b phase_rst %b phase %0d exp 0 0 1", init_start, phase_rst, phase); end
    tick();
    checks++; if (ksa_start !== 1'b0 || phase !== 2'd1) begin errors++; $display("FAIL pass_init_wait ksa_start %b phase %0d exp 0 1", ksa_start, phase); end
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    checks++; if (ksa_start !== 1'b1 || phase !== 2'd2) begin errors++; $display("FAIL pass_ksa_start ksa_start %b phase %0d exp 1 2", ksa_start, phase); end
    tick();
    checks++; if (ksa_start !== 1'b0 || phase !== 2'd2) begin errors++; $display("FAIL pass_ksa_pulse_width ksa_start %b phase %0d exp 0 2", ksa_start, phase); end
    ksa_done = 1'b1;
    tick();
    ksa_done = 1'b0;
    checks++; if (prga_start !== 1'b1 || phase !== 2'd3) begin errors++; $display("FAIL pass_prga_start prga_start %b phase %0d exp 1 3", prga_start, phase); end
    tick();
    checks++; if (prga_start !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pass_prga_run prga_start %b done %b busy %b exp 0 0 1", prga_start, done, busy); end
    prga_done = 1'b1;
    tick();
    prga_done = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || phase !== 2'd0) begin errors++; $display("FAIL pass_done done %b busy %b phase %0d exp 1 0 0", done, busy, phase); end
    tick();
    tick();
    checks++; if (done !== 1'b1 || init_start !== 1'b0) begin errors++; $display("FAIL pass_done_hold done %b init_start %b exp 1 0", done, init_start); end
  endtask

  task automatic test_arbitration();
    do_reset();
    init_addr = 8'h11; init_data = 8'h21; init_wren = 1'b1;
    ksa_addr  = 8'h3C; ksa_data  = 8'h22; ksa_wren  = 1'b0;
    prga_addr = 8'h13; prga_data = 8'h23; prga_wren = 1'b1;
    tick();
    checks++; if (s_addr !== 8'd0 || s_data !== 8'd0 || s_wren !== 1'b0) begin errors++; $display("FAIL arb_idle addr %h data %h wren %b exp 00 00 0", s_addr, s_data, s_wren); end
    key_in = 24'h000001; go = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (s_addr !== 8'h11 || s_data !== 8'h21 || s_wren !== 1'b1) begin errors++; $display("FAIL arb_init_start_fwd addr %h data %h wren %b exp 11 21 1", s_addr, s_data, s_wren); end
    tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    checks++; if (s_addr !== 8'h3C || s_wren !== 1'b0) begin errors++; $display("FAIL arb_ksa_start_fwd addr %h wren %b exp 3c 0", s_addr, s_wren); end
    tick();
    checks++; if (s_addr !== 8'h3C || s_data !== 8'h22 || s_wren !== 1'b0) begin errors++; $display("FAIL arb_ksa_run_block addr %h data %h wren %b exp 3c 22 0", s_addr, s_data, s_wren); end
    ksa_wren = 1'b1; ksa_addr = 8'h7F; ksa_data = 8'hA5;
    #1;
    checks++; if (s_addr !== 8'h7F || s_data !== 8'hA5 || s_wren !== 1'b1) begin errors++; $display("FAIL arb_ksa_run_write addr %h data %h wren %b exp 7f a5 1", s_addr, s_data, s_wren); end
    ksa_done = 1'b1;
    tick();
    ksa_done = 1'b0;
    checks++; if (s_addr !== 8'h13 || s_data !== 8'h23 || s_wren !== 1'b1) begin errors++; $display("FAIL arb_prga_start_fwd addr %h data %h wren %b exp 13 23 1", s_addr, s_data, s_wren); end
    tick();
    prga_done = 1'b1;
    tick();
    prga_done = 1'b0;
    checks++; if (s_addr !== 8'd0 || s_data !== 8'd0 || s_wren !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL arb_done_release addr %h data %h wren %b done %b exp 00 00 0 1", s_addr, s_data, s_wren, done); end
    clear_inputs();
  endtask

  task automatic test_stale_done();
    do_reset();
    ksa_done = 1'b1;
    key_in = 24'h0A0B0C; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (phase !== 2'd1 || ksa_start !== 1'b0 || prga_start !== 1'b0) begin errors++; $display("FAIL stale_no_skip phase %0d ksa_start %b prga_start %b exp 1 0 0", phase, ksa_start, prga_start); end
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    checks++; if (ksa_start !== 1'b1 || phase !== 2'd2) begin errors++; $display("FAIL stale_ksa_start ksa_start %b phase %0d exp 1 2", ksa_start, phase); end
    tick();
    tick();
    ksa_done = 1'b0;
    checks++; if (prga_start !== 1'b1 || phase !== 2'd3) begin errors++; $display("FAIL stale_ksa_level_used prga_start %b phase %0d exp 1 3", prga_start, phase); end
    tick();
  endtask

  // Continues from PRGA_RUN left by test_stale_done.
  task automatic test_go_filtering();
    key_in = 24'hFFEEDD; go = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (phase !== 2'd3 || init_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL go_busy_ignored phase %0d init_start %b busy %b exp 3 0 1", phase, init_start, busy); end
    checks++; if (key_out !== 24'h0A0B0C) begin errors++; $display("FAIL go_busy_key_stable got %h exp 0a0b0c", key_out); end
    tick();
    checks++; if (init_start !== 1'b0 || phase !== 2'd3) begin errors++; $display("FAIL go_not_queued init_start %b phase %0d exp 0 3", init_start, phase); end
    prga_done = 1'b1;
    tick();
    prga_done = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL go_first_done got %b exp 1", done); end
    key_in = 24'h123456; go = 1'b1;
    tick();
    go = 1'b0;
    checks++; if (init_start !== 1'b1 || key_out !== 24'h123456 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL go_second_pass init_start %b key %h done %b busy %b exp 1 123456 0 1", init_start, key_out, done, busy); end
    tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    tick();
    ksa_done = 1'b1;
    tick();
    ksa_done = 1'b0;
    tick();
    prga_done = 1'b1;
    tick();
    prga_done = 1'b0;
    checks++; if (done !== 1'b1 || key_out !== 24'h123456) begin errors++; $display("FAIL go_second_done done %b key %h exp 1 123456", done, key_out); end
  endtask

  task automatic test_reset_mid_pass();
    do_reset();
    drive_to_ksa_run(24'h00BEEF);
    ksa_wren = 1'b1; ksa_addr = 8'h44;
    #1;
    checks++; if (s_wren !== 1'b1 || phase !== 2'd2) begin errors++; $display("FAIL rst_mid_pre wren %b phase %0d exp 1 2", s_wren, phase); end
    reset = 1'b1;
    tick();
    checks++; if (phase !== 2'd0 || busy !== 1'b0 || s_wren !== 1'b0 || s_addr !== 8'd0) begin errors++; $display("FAIL rst_mid_release phase %0d busy %b wren %b addr %h exp 0 0 0 00", phase, busy, s_wren, s_addr); end
    checks++; if (key_out !== 24'd0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_clear key %h done %b exp 000000 0", key_out, done); end
    reset = 1'b0;
    ksa_done = 1'b1;
    tick();
    tick();
    checks++; if (init_start !== 1'b0 || ksa_start !== 1'b0 || prga_start !== 1'b0 || phase !== 2'd0) begin errors++; $display("FAIL rst_mid_no_restart init %b ksa %b prga %b phase %0d exp 0 0 0 0", init_start, ksa_start, prga_start, phase); end
    clear_inputs();
  endtask

`ifdef RC4_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    drive_to_ksa_run(24'h0000AA);
    for (int i = 0; i < 15; i++) tick();
    checks++; if (phase !== 2'd2 || error !== 1'b0) begin errors++; $display("FAIL wdog_before_trip phase %0d error %b exp 2 0", phase, error); end
    tick();
    checks++; if (error !== 1'b1 || phase !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL wdog_trip error %b phase %0d busy %b exp 1 0 0", error, phase, busy); end
    go = 1'b1;
    tick();
    tick();
    go = 1'b0;
    checks++; if (error !== 1'b1 || init_start !== 1'b0) begin errors++; $display("FAIL wdog_go_ignored error %b init_start %b exp 1 0", error, init_start); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wdog_reset_clear got %b exp 0", error); end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_main_pass();
    test_arbitration();
    test_stale_done();
    test_go_filtering();
    test_reset_mid_pass();
`ifdef RC4_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_phase_scheduler.md
# rc4_phase_scheduler

Top-level sequencer for the RC4 decryption core. It runs the three S-memory phases in strict order: S-array initialisation, KSA swap, then PRGA/decrypt. It hands each phase a one-cycle start pulse and waits for that phase's done. It also arbitrates the single-port 256x8 S RAM, so that exactly one phase drives the address, data and write-enable at any time.

## Interface
Parameters:
- `WDOG_CYCLES`, default 8192: per-phase cycle budget. Only used when the watchdog is compiled in.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `go`  in  1  request one full decryption pass. Sampled only in IDLE and DONE.
- `key_in`  in  24  secret key. Latched on `go` acceptance.
- `key_out`  out  24  latched key, fed to the KSA and PRGA blocks.
- `phase_rst`  out  1  one-cycle synchronous reset to all three phase blocks.
- `init_start`, `ksa_start`, `prga_start`  out  1 each  one-cycle start pulses.
- `init_done`, `ksa_done`, `prga_done`  in  1 each  completion from each phase. Level or pulse.
- `init_addr`, `ksa_addr`, `prga_addr`  in  8 each  S RAM address requested by each phase.
- `init_data`, `ksa_data`, `prga_data`  in  8 each  S RAM write data requested by each phase.
- `init_wren`, `ksa_wren`, `prga_wren`  in  1 each  S RAM write enable requested by each phase.
- `s_addr`, `s_data`  out  8 each  to the S RAM port.
- `s_wren`  out  1  to the S RAM port.
- `phase`  out  2  owner of the S RAM port: 0 none, 1 init, 2 ksa, 3 prga.
- `busy`  out  1  high from INIT_START through PRGA_RUN.
- `done`  out  1  high while in DONE.
- `error`  out  1  watchdog trip. Tied 0 when the watchdog is compiled out.

## Operation
- States: IDLE, INIT_START, INIT_RUN, KSA_START, KSA_RUN, PRGA_START, PRGA_RUN, DONE, ERROR.
- IDLE or DONE with `go`=1 -> INIT_START. In the same edge `key_in` is captured into `key_out`.
- INIT_START -> INIT_RUN. In INIT_START, `init_start`=1 and `phase_rst`=1.
- INIT_RUN with `init_done` -> KSA_START.
- KSA_START -> KSA_RUN. In KSA_START, `ksa_start`=1.
- KSA_RUN with `ksa_done` -> PRGA_START.
- PRGA_START -> PRGA_RUN. In PRGA_START, `prga_start`=1.
- PRGA_RUN with `prga_done` -> DONE.
- DONE holds until `go` or `reset`.
- Done inputs are sampled only in the owning RUN state. A done input that is still high from a previous pass, or asserted in any other state, is ignored.
- Phase blocks hold done as a level in their finish state. `phase_rst` clears that level before the next pass.
- `go` is ignored while `busy`=1. It is not queued.
- Arbitration is a combinational mux selected by `phase`:
  - `phase` = 1 in INIT_START and INIT_RUN.
  - `phase` = 2 in KSA_START and KSA_RUN.
  - `phase` = 3 in PRGA_START and PRGA_RUN.
  - `phase` = 0 in IDLE, DONE and ERROR.
- When `phase`=0: `s_addr`=0, `s_data`=0, `s_wren`=0.
- The write enables of non-owning phases are never forwarded to the RAM.
- `key_out` changes only on `go` acceptance and on `reset`. It is stable for an entire pass.

## Timing
- Reset values: state IDLE; `key_out`=0; all start pulses, `phase_rst`, `busy`, `done`, `error`, `s_wren`, `s_addr`, `s_data` = 0; `phase`=0.
- `reset` mid-pass returns to IDLE on the next edge. Start pulses are not re-issued. The RAM port is released (wren 0) from that edge onward.
- Latency `go` -> `init_start`: 1 cycle.
- Latency done-input -> next phase start pulse: 1 cycle.
- Latency `prga_done` -> `done`: 1 cycle.
- Scheduler overhead is 2 cycles per phase plus 1 cycle to DONE.
- Every start pulse is exactly one cycle wide.
- The RAM port switches owner on the same edge that the START state is entered. The new owner's first request in its START cycle is therefore forwarded.
- `go` in the same cycle as `reset`: reset wins.

## Configuration
- `RC4_SCHED_WATCHDOG_EN` defined:
  - A 16-bit cycle counter clears on entry to each START state and increments in RUN states.
  - If the counter reaches `WDOG_CYCLES` in a RUN state before that state's done input, the next state is ERROR.
  - In ERROR: `error`=1, `busy`=0, `phase`=0.
  - ERROR is left only by `reset`. `go` is ignored.
  - A done input arriving in the same cycle the counter reaches `WDOG_CYCLES` takes priority.
- `RC4_SCHED_WATCHDOG_EN` undefined: no counter, ERROR is unreachable, and `error` is tied 0.

## Test plan
- Reset, then `go`=1 for one cycle with `key_in`=24'h000249:
  - `init_start` and `phase_rst` are high in cycle +1; `key_out`=24'h000249.
  - After `init_done`, `ksa_start` follows 1 cycle later. After `ksa_done`, `prga_start` follows 1 cycle later.
  - `done`=1 one cycle after `prga_done`.
- Arbitration:
  - During KSA_RUN, drive `init_wren`=1, `prga_wren`=1, `ksa_wren`=0, `ksa_addr`=8'h3C: `s_wren`=0 and `s_addr`=8'h3C.
  - In IDLE: `s_addr`=0 and `s_wren`=0.
- Hold `ksa_done`=1 from before `go`: it is ignored until KSA_RUN, so there is no skip through INIT.
- `go` pulsed during PRGA_RUN: no restart, and `key_out` is unchanged. `go` pulsed in DONE with a new key: a second pass starts and the new key is latched.
- Assert `reset` during KSA_RUN: IDLE on the next edge, `phase`=0, `busy`=0, `s_wren`=0.
- With `RC4_SCHED_WATCHDOG_EN` and `WDOG_CYCLES`=16, never assert `ksa_done`: `error`=1 after 16 KSA_RUN cycles. It stays 1 through `go` until `reset`.
